// File: rtl/alu_unit_pkg.sv
// Shared defines for the RS / ROB / ALU slice: widths, opcode encodings and the CDB entry layout.
package alu_unit_pkg;

    localparam int DATA_W         = 32;
    localparam int ROB_TAG_W      = 4;
    localparam int OP_W           = 6;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [ROB_TAG_W-1:0] ZERO_ROB_TAG = '0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_ANDI  = 6'd12,
        OP_ORI   = 6'd13,
        OP_XORI  = 6'd14,
        OP_SLLI  = 6'd15,
        OP_SRLI  = 6'd16,
        OP_SRAI  = 6'd17,
        OP_SLTI  = 6'd18,
        OP_SLTIU = 6'd19,
        OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21,
        OP_JAL   = 6'd22,
        OP_JALR  = 6'd23,
        OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25,
        OP_BLT   = 6'd26,
        OP_BGE   = 6'd27,
        OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } op_e;

    localparam logic [OP_W-1:0] NOP = OP_NOP;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] reorder;
        logic [DATA_W-1:0]    value;
        logic                 jump;
        logic [DATA_W-1:0]    pc_next;
    } cdb_entry_t;

    // I-form opcodes take the immediate in place of operand 2.
    function automatic logic is_imm_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
            OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Issue-side and CDB-side bus between the reservation station / arbiter and the ALU unit.
interface alu_unit_if;
    import alu_unit_pkg::*;

    logic [OP_W-1:0]      in_rs_op;
    logic [DATA_W-1:0]    in_rs_value_rs1;
    logic [DATA_W-1:0]    in_rs_value_rs2;
    logic [DATA_W-1:0]    in_rs_imm;
    logic [DATA_W-1:0]    in_rs_pc;
    logic [ROB_TAG_W-1:0] in_rs_reorder;
    logic                 out_rs_full;
    logic                 in_cdb_grant;
    logic                 in_rob_flush;
    logic                 out_cdb_valid;
    logic [ROB_TAG_W-1:0] out_cdb_reorder;
    logic [DATA_W-1:0]    out_cdb_value;
    logic                 out_cdb_jump;
    logic [DATA_W-1:0]    out_cdb_pc_next;

    modport master (
        output in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm, in_rs_pc,
               in_rs_reorder, in_cdb_grant, in_rob_flush,
        input  out_rs_full, out_cdb_valid, out_cdb_reorder, out_cdb_value,
               out_cdb_jump, out_cdb_pc_next
    );

    modport slave (
        input  in_rs_op, in_rs_value_rs1, in_rs_value_rs2, in_rs_imm, in_rs_pc,
               in_rs_reorder, in_cdb_grant, in_rob_flush,
        output out_rs_full, out_cdb_valid, out_cdb_reorder, out_cdb_value,
               out_cdb_jump, out_cdb_pc_next
    );

endinterface

// File: rtl/alu_unit_core.sv
// Purely combinational ALU: produces rd value, jump flag and next pc for one instruction.
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] value,
    output logic              jump,
    output logic [DATA_W-1:0] pc_next
);

    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] pc_plus_imm;
    logic [4:0]        shamt;
    logic              eq;
    logic              lt_s;
    logic              lt_u;

    // Branches are never I-forms, so op2 is rs2 whenever the comparators feed a branch.
    assign op2         = is_imm_op(op) ? imm : rs2;
    assign shamt       = op2[4:0];
    assign pc_plus4    = pc + DATA_W'(4);
    assign pc_plus_imm = pc + imm;
    assign eq          = (rs1 == op2);
    assign lt_s        = ($signed(rs1) < $signed(op2));
    assign lt_u        = (rs1 < op2);

    always_comb begin
        value   = '0;
        jump    = 1'b0;
        pc_next = pc_plus4;
        case (op)
            OP_ADD,  OP_ADDI:  value = rs1 + op2;
            OP_SUB:            value = rs1 - op2;
            OP_AND,  OP_ANDI:  value = rs1 & op2;
            OP_OR,   OP_ORI:   value = rs1 | op2;
            OP_XOR,  OP_XORI:  value = rs1 ^ op2;
            OP_SLL,  OP_SLLI:  value = rs1 << shamt;
            OP_SRL,  OP_SRLI:  value = rs1 >> shamt;
            OP_SRA,  OP_SRAI:  value = $unsigned($signed(rs1) >>> shamt);
            OP_SLT,  OP_SLTI:  value = DATA_W'(lt_s);
            OP_SLTU, OP_SLTIU: value = DATA_W'(lt_u);
            OP_LUI:            value = imm;
            OP_AUIPC:          value = pc_plus_imm;
            OP_JAL: begin
                value   = pc_plus4;
                jump    = 1'b1;
                pc_next = pc_plus_imm;
            end
            OP_JALR: begin
                value   = pc_plus4;
                jump    = 1'b1;
                pc_next = (rs1 + imm) & ~DATA_W'(1);
            end
            OP_BEQ: begin
                jump    = eq;
                pc_next = eq ? pc_plus_imm : pc_plus4;
            end
            OP_BNE: begin
                jump    = !eq;
                pc_next = !eq ? pc_plus_imm : pc_plus4;
            end
            OP_BLT: begin
                jump    = lt_s;
                pc_next = lt_s ? pc_plus_imm : pc_plus4;
            end
            OP_BGE: begin
                jump    = !lt_s;
                pc_next = !lt_s ? pc_plus_imm : pc_plus4;
            end
            OP_BLTU: begin
                jump    = lt_u;
                pc_next = lt_u ? pc_plus_imm : pc_plus4;
            end
            OP_BGEU: begin
                jump    = !lt_u;
                pc_next = !lt_u ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: computes issued instructions and queues results in order for the CDB.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    alu_unit_if.slave  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    cdb_entry_t        mem [FIFO_DEPTH];
    cdb_entry_t        result;
    cdb_entry_t        head_entry;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              full_q;
    logic              valid;
    logic              issue;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] core_value;
    logic              core_jump;
    logic [DATA_W-1:0] core_pc_next;

    alu_core u_core (
        .op      (bus.in_rs_op),
        .rs1     (bus.in_rs_value_rs1),
        .rs2     (bus.in_rs_value_rs2),
        .imm     (bus.in_rs_imm),
        .pc      (bus.in_rs_pc),
        .value   (core_value),
        .jump    (core_jump),
        .pc_next (core_pc_next)
    );

    assign result = '{reorder: bus.in_rs_reorder, value: core_value,
                      jump: core_jump, pc_next: core_pc_next};

    // A push into a full FIFO is only accepted when the head leaves at the same edge.
    assign valid = (count != '0);
    assign issue = (bus.in_rs_op != NOP) && !bus.in_rob_flush;
    assign pop   = valid && bus.in_cdb_grant;
    assign push  = issue && ((count != CNT_W'(FIFO_DEPTH)) || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else if (rdy) begin
            if (bus.in_rob_flush) begin
                head   <= '0;
                tail   <= '0;
                count  <= '0;
                full_q <= 1'b0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                count  <= count_next;
                full_q <= (count_next >= CNT_W'(FIFO_DEPTH - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && push) mem[tail] <= result;
    end

    // Outputs come straight from the head entry and read as zero while the FIFO is empty.
    assign head_entry          = mem[head];
    assign bus.out_cdb_valid   = valid;
    assign bus.out_cdb_reorder = valid ? head_entry.reorder : ZERO_ROB_TAG;
    assign bus.out_cdb_value   = valid ? head_entry.value   : '0;
    assign bus.out_cdb_jump    = valid && head_entry.jump;
    assign bus.out_cdb_pc_next = valid ? head_entry.pc_next : '0;
    assign bus.out_rs_full     = full_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: hand-computed vectors for compute, FIFO ordering, full, flush and freeze.
module tb_alu_unit;
    import alu_unit_pkg::*;

    typedef struct {
        logic [OP_W-1:0]      op;
        logic [DATA_W-1:0]    rs1;
        logic [DATA_W-1:0]    rs2;
        logic [DATA_W-1:0]    imm;
        logic [DATA_W-1:0]    pc;
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    value;
        logic                 jump;
        logic [DATA_W-1:0]    pc_next;
    } vec_t;

    logic clk;
    logic rst;
    logic rdy;
    int   n_vec;
    int   n_fail;
    vec_t vecs[$];

    alu_unit_if bus ();

    alu_unit dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [OP_W-1:0] op, input logic [31:0] rs1,
                                  input logic [31:0] rs2, input logic [31:0] imm,
                                  input logic [31:0] pc, input logic [3:0] tag);
        bus.in_rs_op        = op;
        bus.in_rs_value_rs1 = rs1;
        bus.in_rs_value_rs2 = rs2;
        bus.in_rs_imm       = imm;
        bus.in_rs_pc        = pc;
        bus.in_rs_reorder   = tag;
    endtask

    task automatic idle();
        apply_stimulus(NOP, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [3:0] tag, input logic [31:0] value);
        check_output({name, ".valid"}, bus.out_cdb_valid, 1);
        check_output({name, ".reorder"}, bus.out_cdb_reorder, tag);
        check_output({name, ".value"}, bus.out_cdb_value, value);
    endtask

    function automatic void add_vec(input logic [OP_W-1:0] op, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    input logic [31:0] pc, input logic [3:0] tag,
                                    input logic [31:0] value, input logic jump,
                                    input logic [31:0] pc_next);
        vecs.push_back('{op, rs1, rs2, imm, pc, tag, value, jump, pc_next});
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b0;
        rdy    = 1'b1;
        bus.in_cdb_grant = 1'b0;
        bus.in_rob_flush = 1'b0;
        idle();

        tick();
        tick();
        check_output("rst.valid", bus.out_cdb_valid, 0);
        check_output("rst.reorder", bus.out_cdb_reorder, 0);
        check_output("rst.value", bus.out_cdb_value, 0);
        check_output("rst.jump", bus.out_cdb_jump, 0);
        check_output("rst.pc_next", bus.out_cdb_pc_next, 0);
        check_output("rst.full", bus.out_rs_full, 0);
        rst = 1'b1;

        // Back-to-back stream with grant high: each edge pops the old head and pushes the new one.
        add_vec(OP_ADDI,  32'd5,        32'd0,        32'hFFFFFFF9, 32'h40,   4'd3,  32'hFFFFFFFE, 1'b0, 32'h44);
        add_vec(OP_BLT,   32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  4'd4,  32'h0,        1'b1, 32'h120);
        add_vec(OP_BLTU,  32'hFFFFFFFF, 32'd1,        32'h20,       32'h100,  4'd5,  32'h0,        1'b0, 32'h104);
        add_vec(OP_SUB,   32'd3,        32'd5,        32'h0,        32'h100,  4'd6,  32'hFFFFFFFE, 1'b0, 32'h104);
        add_vec(OP_SRA,   32'h80000000, 32'h24,       32'h0,        32'h100,  4'd7,  32'hF8000000, 1'b0, 32'h104);
        add_vec(OP_SRLI,  32'h80000000, 32'h0,        32'h4,        32'h100,  4'd8,  32'h08000000, 1'b0, 32'h104);
        add_vec(OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'h0,        32'h100,  4'd9,  32'h1,        1'b0, 32'h104);
        add_vec(OP_SLT,   32'd1,        32'hFFFFFFFF, 32'h0,        32'h100,  4'd10, 32'h0,        1'b0, 32'h104);
        add_vec(OP_LUI,   32'd0,        32'd0,        32'h12345000, 32'h100,  4'd11, 32'h12345000, 1'b0, 32'h104);
        add_vec(OP_AUIPC, 32'd0,        32'd0,        32'h2000,     32'h1000, 4'd12, 32'h3000,     1'b0, 32'h1004);
        add_vec(OP_JAL,   32'd0,        32'd0,        32'h10,       32'h200,  4'd13, 32'h204,      1'b1, 32'h210);
        add_vec(OP_JALR,  32'h1001,     32'd0,        32'h4,        32'h300,  4'd14, 32'h304,      1'b1, 32'h1004);
        add_vec(OP_BEQ,   32'd7,        32'd7,        32'hFFFFFFF0, 32'h400,  4'd15, 32'h0,        1'b1, 32'h3F0);
        add_vec(OP_BGE,   32'hFFFFFFFF, 32'd1,        32'h8,        32'h400,  4'd1,  32'h0,        1'b0, 32'h404);
        add_vec(6'd63,    32'd1,        32'd2,        32'h0,        32'h500,  4'd2,  32'h0,        1'b0, 32'h504);
        add_vec(OP_XORI,  32'hFF00FF00, 32'd0,        32'hFFFFFFFF, 32'h100,  4'd3,  32'h00FF00FF, 1'b0, 32'h104);
        add_vec(OP_SLL,   32'd1,        32'h21,       32'h0,        32'h100,  4'd4,  32'h2,        1'b0, 32'h104);

        bus.in_cdb_grant = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc, vecs[i].tag);
            tick();
            check_head($sformatf("stream%0d", i), vecs[i].tag, vecs[i].value);
            check_output($sformatf("stream%0d.jump", i), bus.out_cdb_jump, vecs[i].jump);
            check_output($sformatf("stream%0d.pc_next", i), bus.out_cdb_pc_next, vecs[i].pc_next);
        end
        idle();
        tick();
        check_output("stream_end.valid", bus.out_cdb_valid, 0);

        // Grant held low: three pushes raise full and the head stays put.
        bus.in_cdb_grant = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            apply_stimulus(OP_ADD, t, 32'd10, 0, 32'h100, 4'(t));
            tick();
            check_output($sformatf("fill%0d.full", t), bus.out_rs_full, (t == 3) ? 1 : 0);
        end
        idle();
        tick();
        check_head("hold", 4'd1, 32'd11);
        bus.in_cdb_grant = 1'b1;
        tick();
        check_head("drain2", 4'd2, 32'd12);
        check_output("drain2.full", bus.out_rs_full, 0);
        tick();
        check_head("drain3", 4'd3, 32'd13);
        tick();
        check_output("drain_end.valid", bus.out_cdb_valid, 0);

        // Sit at DEPTH-1 with simultaneous issue and grant over 10 ops so the pointers wrap.
        bus.in_cdb_grant = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            apply_stimulus(OP_ADD, t, 32'd100, 0, 32'h100, 4'(t));
            tick();
        end
        bus.in_cdb_grant = 1'b1;
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(OP_ADD, k + 4, 32'd100, 0, 32'h100, 4'(k + 4));
            tick();
            check_head($sformatf("wrap%0d", k), 4'(k + 2), 32'(k + 102));
            check_output($sformatf("wrap%0d.full", k), bus.out_rs_full, 1);
        end
        idle();
        tick();
        check_head("wrap_drain12", 4'd12, 32'd112);
        check_output("wrap_drain12.full", bus.out_rs_full, 0);
        tick();
        check_head("wrap_drain13", 4'd13, 32'd113);
        tick();
        check_output("wrap_end.valid", bus.out_cdb_valid, 0);

        // Issue into a completely full FIFO with no pop: the fifth entry is dropped.
        bus.in_cdb_grant = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            apply_stimulus(OP_ADD, t, 32'd0, 0, 32'h100, 4'(t));
            tick();
        end
        idle();
        check_head("over.head", 4'd1, 32'd1);
        bus.in_cdb_grant = 1'b1;
        for (int t = 2; t <= 4; t++) begin
            tick();
            check_head($sformatf("over_drain%0d", t), 4'(t), 32'(t));
        end
        tick();
        check_output("over_end.valid", bus.out_cdb_valid, 0);

        // Flush with two pending entries and a concurrent issue and grant.
        bus.in_cdb_grant = 1'b0;
        apply_stimulus(OP_ADD, 32'd7, 32'd0, 0, 32'h100, 4'd7);
        tick();
        apply_stimulus(OP_ADD, 32'd8, 32'd0, 0, 32'h100, 4'd8);
        tick();
        bus.in_cdb_grant = 1'b1;
        bus.in_rob_flush = 1'b1;
        apply_stimulus(OP_ADD, 32'd9, 32'd0, 0, 32'h100, 4'd9);
        tick();
        bus.in_rob_flush = 1'b0;
        idle();
        check_output("flush.valid", bus.out_cdb_valid, 0);
        check_output("flush.full", bus.out_rs_full, 0);
        tick();
        check_output("flush_after.valid", bus.out_cdb_valid, 0);
        bus.in_cdb_grant = 1'b0;
        apply_stimulus(OP_ADD, 32'd10, 32'd0, 0, 32'h100, 4'd10);
        tick();
        check_head("post_flush", 4'd10, 32'd10);
        bus.in_cdb_grant = 1'b1;
        idle();
        tick();
        check_output("post_flush_end.valid", bus.out_cdb_valid, 0);

        // rdy low freezes everything: grant, flush and issue are all ignored.
        bus.in_cdb_grant = 1'b0;
        apply_stimulus(OP_ADD, 32'd1, 32'd0, 0, 32'h100, 4'd1);
        tick();
        apply_stimulus(OP_ADD, 32'd2, 32'd0, 0, 32'h100, 4'd2);
        tick();
        rdy = 1'b0;
        bus.in_cdb_grant = 1'b1;
        bus.in_rob_flush = 1'b1;
        apply_stimulus(OP_ADD, 32'd3, 32'd0, 0, 32'h100, 4'd3);
        tick();
        tick();
        check_head("frozen", 4'd1, 32'd1);
        check_output("frozen.pc_next", bus.out_cdb_pc_next, 32'h104);
        rdy = 1'b1;
        bus.in_rob_flush = 1'b0;
        idle();
        tick();
        check_head("thaw", 4'd2, 32'd2);
        tick();
        check_output("thaw_end.valid", bus.out_cdb_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Execution unit on the issue side of the reservation station: accepts one ready instruction per cycle from the RS (opcode, operand values, imm, pc, ROB tag), computes the result, and broadcasts it on the common data bus (CDB) to ROB and RS. Results wait in an in-order result FIFO until the CDB arbiter grants a slot. A registered almost-full flag throttles the RS.

## Interface
Parameters:
- DATA_W, 32, operand/result/pc width
- ROB_TAG_W, 4, ROB tag width; tag 0 = "no instruction"
- OP_W, 6, inside-opcode width; NOP = 0
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; low = freeze all state
- in_rs_op  in  OP_W  issued opcode; NOP = no issue
- in_rs_value_rs1  in  DATA_W  operand 1
- in_rs_value_rs2  in  DATA_W  operand 2
- in_rs_imm  in  DATA_W  sign-extended immediate
- in_rs_pc  in  DATA_W  instruction pc
- in_rs_reorder  in  ROB_TAG_W  destination ROB tag
- out_rs_full  out  1  RS must not issue next cycle
- in_cdb_grant  in  1  arbiter accepts current CDB head this cycle
- in_rob_flush  in  1  misprediction clear
- out_cdb_valid  out  1  head result present
- out_cdb_reorder  out  ROB_TAG_W  head ROB tag
- out_cdb_value  out  DATA_W  rd value
- out_cdb_jump  out  1  control transfer taken
- out_cdb_pc_next  out  DATA_W  next pc for branch/jal/jalr

## Operation
- Issue = in_rs_op != NOP and in_rob_flush low; result computed combinationally and pushed into FIFO tail at that edge.
- Opcodes: ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU and I-forms (operand 2 = imm), LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU.
- Arithmetic modulo 2^DATA_W; shifts use operand2[4:0]; SLT/BLT/BGE signed, *U variants unsigned.
- LUI: value=imm. AUIPC: value=pc+imm. Non-control ops: jump=0, pc_next=pc+4.
- JAL: value=pc+4, jump=1, pc_next=pc+imm. JALR: value=pc+4, jump=1, pc_next=(rs1+imm)&~1.
- Branch: value=0, jump=cond, pc_next = cond ? pc+imm : pc+4.
- Unknown non-NOP opcode: push value=0, jump=0, pc_next=pc+4.
- Pop when out_cdb_valid && in_cdb_grant; grant with empty FIFO ignored.
- Push+pop same edge: count unchanged, order preserved (pointer wrap mod FIFO_DEPTH).
- Flush: FIFO emptied at that edge; concurrent issue and pop discarded.
- Issue while count==FIFO_DEPTH and no pop is a protocol violation; entry dropped, count unchanged.
- rdy low: no push, no pop, no flush; all outputs hold.

## Timing
- Reset (rst low at edge): FIFO empty; out_cdb_valid=0, out_cdb_reorder=0, out_cdb_value=0, out_cdb_jump=0, out_cdb_pc_next=0, out_rs_full=0.
- Latency: issue sampled at edge N → on CDB in cycle after N if FIFO was empty or head popped at N.
- CDB outputs driven from FIFO head registers only; held stable until granted.
- out_rs_full registered: high when post-edge count ≥ FIFO_DEPTH-1 (one-slot margin covers RS registered issue).
- Throughput: one issue and one broadcast per cycle sustained while granted.
- Flush: out_cdb_valid=0 the cycle after flush edge.

## Structure
- Opcode encodings, NOP, DATA_W/ROB_TAG_W/OP_W and ZERO_ROB_TAG in shared defines package with RS and ROB.
- Sub-module alu_core: pure combinational compute (op, rs1, rs2, imm, pc → value, jump, pc_next); alu_unit holds FIFO, count, pointers, full flag.

## Test plan
- Reset: rst low 2 cycles → all outputs 0, out_rs_full=0.
- ADDI rs1=5 imm=-7 tag 3, grant tied high → next cycle valid=1, reorder=3, value=0xFFFFFFFE, jump=0.
- BLT rs1=-1 rs2=1 pc=0x100 imm=0x20 → jump=1, pc_next=0x120; BLTU same operands → jump=0, pc_next=0x104.
- Grant held low, issue 3 ops tags 1,2,3 → out_rs_full high after 3rd push; release grant → broadcasts 1,2,3 in order, full drops.
- Count=FIFO_DEPTH-1, simultaneous issue+grant → count unchanged, order preserved; pointer wrap exercised over 10 ops.
- Two entries pending, in_rob_flush with concurrent issue → next cycle valid=0, count 0; rdy low mid-stream → outputs frozen.
